// File: rtl/mem_stage_if.sv
// Execute->memory->writeback handshake, SRAM response and forwarding bundle for mem_stage.
interface mem_stage_if #(
  parameter int unsigned CSR_W = 79,
  parameter int unsigned EX_W  = 10
);
  localparam int unsigned MW_W = 70 + EX_W + CSR_W;
  localparam int unsigned MD_W = 39;

  logic             W_allowin;
  logic             M_allowin;
  logic             EM_valid;
  logic [31:0]      em_pc;
  logic [31:0]      em_rf_wdata;
  logic             em_gr_we;
  logic [4:0]       em_dest;
  logic [3:0]       em_res_from_mem;
  logic             em_mem_req;
  logic [1:0]       em_addr_lo;
  logic [EX_W-1:0]  em_ex;
  logic [CSR_W-1:0] em_csr;
  logic             flush;
  logic             data_sram_data_ok;
  logic [31:0]      data_sram_rdata;
  logic             MW_valid;
  logic [MW_W-1:0]  MW_bus;
  logic [MD_W-1:0]  MD_for_bus;

  // Upstream/downstream environment side.
  modport master (
    output W_allowin, EM_valid, em_pc, em_rf_wdata, em_gr_we, em_dest,
           em_res_from_mem, em_mem_req, em_addr_lo, em_ex, em_csr, flush,
           data_sram_data_ok, data_sram_rdata,
    input  M_allowin, MW_valid, MW_bus, MD_for_bus
  );

  // Memory stage side.
  modport slave (
    input  W_allowin, EM_valid, em_pc, em_rf_wdata, em_gr_we, em_dest,
           em_res_from_mem, em_mem_req, em_addr_lo, em_ex, em_csr, flush,
           data_sram_data_ok, data_sram_rdata,
    output M_allowin, MW_valid, MW_bus, MD_for_bus
  );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: waits for the data SRAM response, aligns/extends load data,
// hands the result to writeback and drops responses orphaned by a flush.
// Optional macro MEM_FAST_DATA_OK_EN: forward the SRAM response in the data_ok cycle.
module mem_stage #(
  parameter int unsigned CSR_W = 79,
  parameter int unsigned EX_W  = 10
) (
  input  logic        clk,
  input  logic        rstn,
  mem_stage_if.slave  bus
);
  localparam int unsigned CSR_WE_BIT = CSR_W - 15;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state, state_n;
  logic             m_valid, m_valid_n;
  logic [1:0]       drop_cnt, drop_cnt_n;

  logic [31:0]      pc_r;
  logic [31:0]      rf_wdata_r;
  logic             gr_we_r;
  logic [4:0]       dest_r;
  logic [3:0]       rfm_r;
  logic [1:0]       addr_lo_r;
  logic [EX_W-1:0]  ex_r;
  logic [CSR_W-1:0] csr_r;
  logic [31:0]      rdata_r;

  logic             resp_ok;
  logic             ready_go;
  logic             m_allowin;
  logic             capture;
  logic             drop_inc;
  logic             drop_dec;
  logic             is_load;
  logic [31:0]      ld_src;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic             ld_sext;
  logic [31:0]      final_wdata;

  // Handshake: a response only counts once all stale ones have been dropped.
  always_comb begin
    resp_ok   = (state == WAIT) && bus.data_sram_data_ok && (drop_cnt == 2'd0);
`ifdef MEM_FAST_DATA_OK_EN
    ready_go  = (state == DONE) || resp_ok;
`else
    ready_go  = (state == DONE);
`endif
    m_allowin = !m_valid || (ready_go && bus.W_allowin);
    capture   = bus.EM_valid && m_allowin && !bus.flush;
  end

  // State, valid and drop-counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      m_valid  <= 1'b0;
      drop_cnt <= 2'd0;
    end else begin
      state    <= state_n;
      m_valid  <= m_valid_n;
      drop_cnt <= drop_cnt_n;
    end
  end

  // Next state; a flush orphans an outstanding request, which is then counted for dropping.
  always_comb begin
    state_n    = state;
    m_valid_n  = m_valid;
    drop_cnt_n = drop_cnt;
    drop_inc   = bus.flush && (state == WAIT) && !resp_ok;
    drop_dec   = bus.data_sram_data_ok && (drop_cnt != 2'd0);
    if (drop_inc && !drop_dec) begin
      drop_cnt_n = (drop_cnt == 2'd3) ? drop_cnt : drop_cnt + 2'd1;
    end else if (drop_dec && !drop_inc) begin
      drop_cnt_n = drop_cnt - 2'd1;
    end
    if (bus.flush) begin
      state_n   = IDLE;
      m_valid_n = 1'b0;
    end else if (capture) begin
      m_valid_n = 1'b1;
      state_n   = (bus.em_mem_req && !bus.em_ex[0]) ? WAIT : DONE;
    end else begin
      case (state)
        WAIT: begin
          if (resp_ok) begin
            if (ready_go && bus.W_allowin) begin
              state_n   = IDLE;
              m_valid_n = 1'b0;
            end else begin
              state_n = DONE;
            end
          end
        end
        DONE: begin
          if (bus.W_allowin) begin
            state_n   = IDLE;
            m_valid_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Payload capture from execute and response capture from the SRAM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_r       <= 32'd0;
      rf_wdata_r <= 32'd0;
      gr_we_r    <= 1'b0;
      dest_r     <= 5'd0;
      rfm_r      <= 4'd0;
      addr_lo_r  <= 2'd0;
      ex_r       <= '0;
      csr_r      <= '0;
      rdata_r    <= 32'd0;
    end else begin
      if (capture) begin
        pc_r       <= bus.em_pc;
        rf_wdata_r <= bus.em_rf_wdata;
        gr_we_r    <= bus.em_gr_we;
        dest_r     <= bus.em_dest;
        rfm_r      <= bus.em_res_from_mem;
        addr_lo_r  <= bus.em_addr_lo;
        ex_r       <= bus.em_ex;
        csr_r      <= bus.em_csr;
      end
      if (resp_ok) begin
        rdata_r <= bus.data_sram_rdata;
      end
    end
  end

  // Load alignment and sign/zero extension.
  always_comb begin
`ifdef MEM_FAST_DATA_OK_EN
    ld_src = resp_ok ? bus.data_sram_rdata : rdata_r;
`else
    ld_src = rdata_r;
`endif
    ld_byte = 8'(ld_src >> {addr_lo_r, 3'b000});
    ld_half = 16'(ld_src >> {addr_lo_r[1], 4'b0000});
    ld_sext = !rfm_r[2];
    is_load = rfm_r[3] || rfm_r[1] || rfm_r[0];
    if (rfm_r[3]) begin
      final_wdata = ld_src;
    end else if (rfm_r[1]) begin
      final_wdata = {{16{ld_sext & ld_half[15]}}, ld_half};
    end else if (rfm_r[0]) begin
      final_wdata = {{24{ld_sext & ld_byte[7]}}, ld_byte};
    end else begin
      final_wdata = rf_wdata_r;
    end
  end

  assign bus.M_allowin  = m_allowin;
  assign bus.MW_valid   = m_valid && ready_go && !bus.flush;
  assign bus.MW_bus     = {pc_r, final_wdata, gr_we_r, dest_r, ex_r, csr_r};
  assign bus.MD_for_bus = {m_valid && (state == WAIT) && is_load,
                           (m_valid && gr_we_r) ? dest_r : 5'd0,
                           final_wdata,
                           csr_r[CSR_WE_BIT] && m_valid};

  // A fourth orphaned response cannot be tracked by the 2-bit drop counter.
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(drop_inc && !drop_dec && (drop_cnt == 2'd3)));
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage.
module tb_mem_stage;
  localparam int unsigned CSR_W = 79;
  localparam int unsigned EX_W  = 10;
  localparam int unsigned MW_W  = 70 + EX_W + CSR_W;
`ifdef MEM_FAST_DATA_OK_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  logic [MW_W-1:0] sb[$];
  logic [MW_W-1:0] mon_exp;
  logic [MW_W-1:0] hold_exp;
  int   waited;

  mem_stage_if #(.CSR_W(CSR_W), .EX_W(EX_W)) bus ();

  mem_stage #(.CSR_W(CSR_W), .EX_W(EX_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [MW_W-1:0] obs, input logic [MW_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_model(input logic [3:0] rfm, input logic [1:0] lo,
                                             input logic [31:0] rd, input logic [31:0] alu);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    if (rfm[3]) return rd;
    if (rfm[1]) return rfm[2] ? {16'h0, h} : {{16{h[15]}}, h};
    if (rfm[0]) return rfm[2] ? {24'h0, b} : {{24{b[7]}}, b};
    return alu;
  endfunction

  // Writeback transfers are compared against the scoreboard in issue order.
  always @(negedge clk) begin
    if (rstn && bus.MW_valid && bus.W_allowin) begin
      if (sb.size() > 0) mon_exp = sb.pop_front();
      else               mon_exp = 'x;
      chk("mw_bus", bus.MW_bus, mon_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] wd, input logic gw,
                      input logic [4:0] dst, input logic [3:0] rfm, input logic req,
                      input logic [1:0] lo, input logic [EX_W-1:0] ex,
                      input logic [CSR_W-1:0] csr, input logic [31:0] rd,
                      input bit push, output int n);
    n = 0;
    bus.EM_valid        = 1'b1;
    bus.em_pc           = pc;
    bus.em_rf_wdata     = wd;
    bus.em_gr_we        = gw;
    bus.em_dest         = dst;
    bus.em_res_from_mem = rfm;
    bus.em_mem_req      = req;
    bus.em_addr_lo      = lo;
    bus.em_ex           = ex;
    bus.em_csr          = csr;
    @(negedge clk);
    while (!bus.M_allowin && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", MW_W'(bus.M_allowin), MW_W'(1));
    if (push) sb.push_back({pc, load_model(rfm, lo, rd, wd), gw, dst, ex, csr});
    @(posedge clk);
    #1;
    bus.EM_valid = 1'b0;
  endtask

  task automatic resp(input logic [31:0] d);
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = d;
    @(posedge clk);
    #1;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'd0;
  endtask

  initial begin
    bus.W_allowin = 1'b1;
    bus.EM_valid = 1'b0;
    bus.em_pc = '0; bus.em_rf_wdata = '0; bus.em_gr_we = 1'b0; bus.em_dest = '0;
    bus.em_res_from_mem = '0; bus.em_mem_req = 1'b0; bus.em_addr_lo = '0;
    bus.em_ex = '0; bus.em_csr = '0; bus.flush = 1'b0;
    bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_mw_valid", MW_W'(bus.MW_valid), MW_W'(0));
    chk("rst_allowin", MW_W'(bus.M_allowin), MW_W'(1));
    chk("rst_md", MW_W'(bus.MD_for_bus), MW_W'(0));
    rstn = 1'b1;
    cyc();

    // ld.w, response three cycles after capture
    send(32'h1000, 32'h0000_dead, 1'b1, 5'd5, 4'b1000, 1'b1, 2'd0, '0, '0, 32'h8000_00F0, 1'b1, waited);
    chk("t1_wait_allowin0", MW_W'(bus.M_allowin), MW_W'(0));
    chk("t1_pending", MW_W'(bus.MD_for_bus[38]), MW_W'(1));
    cyc();
    chk("t1_wait_allowin1", MW_W'(bus.M_allowin), MW_W'(0));
    cyc();
    chk("t1_wait_allowin2", MW_W'(bus.M_allowin), MW_W'(0));
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h8000_00F0;
    @(negedge clk);
    chk("t1_dataok_mw_valid", MW_W'(bus.MW_valid), MW_W'(FAST));
    chk("t1_dataok_allowin", MW_W'(bus.M_allowin), MW_W'(FAST));
    @(posedge clk);
    #1;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'd0;
    @(negedge clk);
    chk("t1_next_mw_valid", MW_W'(bus.MW_valid), MW_W'(!FAST));
    chk("t1_md", MW_W'(bus.MD_for_bus),
        FAST ? MW_W'({1'b0, 5'd0, 32'h8000_00F0, 1'b0}) : MW_W'({1'b0, 5'd5, 32'h8000_00F0, 1'b0}));
    cyc();

    // ld.b signed at byte 3, ld.hu at half 1
    send(32'h1004, 32'h0, 1'b1, 5'd6, 4'b0001, 1'b1, 2'd3, '0, '0, 32'h80FF_FFFF, 1'b1, waited);
    resp(32'h80FF_FFFF);
    @(negedge clk);
    chk("t2_ldb", MW_W'(bus.MD_for_bus[32:1]), MW_W'(32'hFFFF_FF80));
    cyc();
    send(32'h1008, 32'h0, 1'b1, 5'd7, 4'b0110, 1'b1, 2'd2, '0, '0, 32'h8001_0000, 1'b1, waited);
    resp(32'h8001_0000);
    @(negedge clk);
    chk("t2_ldhu", MW_W'(bus.MD_for_bus[32:1]), MW_W'(32'h0000_8001));
    cyc(); cyc();

    // Flush in WAIT, new load captured, stale response dropped
    send(32'h2000, 32'h0, 1'b1, 5'd8, 4'b1000, 1'b1, 2'd0, '0, '0, 32'h0, 1'b0, waited);
    cyc();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("t3_flush_mw_valid", MW_W'(bus.MW_valid), MW_W'(0));
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("t3_drop1", MW_W'(dut.drop_cnt), MW_W'(1));
    chk("t3_allowin", MW_W'(bus.M_allowin), MW_W'(1));
    send(32'h2004, 32'h0, 1'b1, 5'd9, 4'b1000, 1'b1, 2'd0, '0, '0, 32'h2222_2222, 1'b1, waited);
    resp(32'h1111_1111);
    chk("t3_drop0", MW_W'(dut.drop_cnt), MW_W'(0));
    chk("t3_still_wait", MW_W'(bus.M_allowin), MW_W'(0));
    chk("t3_pending", MW_W'(bus.MD_for_bus[38]), MW_W'(1));
    resp(32'h2222_2222);
    @(negedge clk);
    chk("t3_drop_end", MW_W'(dut.drop_cnt), MW_W'(0));
    cyc();

    // Non-memory op held by writeback back-pressure
    bus.W_allowin = 1'b0;
    send(32'h3000, 32'h1234_5678, 1'b1, 5'd10, 4'b0000, 1'b0, 2'd0, '0, '0, 32'h0, 1'b1, waited);
    hold_exp = {32'h3000, 32'h1234_5678, 1'b1, 5'd10, EX_W'(0), CSR_W'(0)};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_hold_bus", bus.MW_bus, hold_exp);
      chk("t4_hold_allowin", MW_W'(bus.M_allowin), MW_W'(0));
      chk("t4_hold_valid", MW_W'(bus.MW_valid), MW_W'(1));
      @(posedge clk);
      #1;
    end
    bus.W_allowin = 1'b1;
    send(32'h3004, 32'hCAFE_F00D, 1'b1, 5'd11, 4'b0000, 1'b0, 2'd0, '0, '0, 32'h0, 1'b1, waited);
    chk("t4_same_cycle", MW_W'(waited), MW_W'(0));
    cyc();

    // Exception on entry: DONE without a response, sidebands passed through
    send(32'h4000, 32'h55AA_55AA, 1'b0, 5'd0, 4'b0000, 1'b1, 2'd1, 10'h2A5,
         {14'h0180, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001}, 32'h0, 1'b1, waited);
    @(negedge clk);
    chk("t6_done_valid", MW_W'(bus.MW_valid), MW_W'(1));
    chk("t6_csr_we", MW_W'(bus.MD_for_bus[0]), MW_W'(1));
    cyc(); cyc();

    // Asynchronous reset while a load is outstanding
    send(32'h5000, 32'h0, 1'b1, 5'd12, 4'b1000, 1'b1, 2'd0, '0, '0, 32'h0, 1'b0, waited);
    chk("t5_pending_before", MW_W'(bus.MD_for_bus[38]), MW_W'(1));
    #3;
    rstn = 1'b0;
    #1;
    chk("t5_mw_valid", MW_W'(bus.MW_valid), MW_W'(0));
    chk("t5_md", MW_W'(bus.MD_for_bus), MW_W'(0));
    chk("t5_state", MW_W'(dut.state), MW_W'(0));
    chk("t5_drop", MW_W'(dut.drop_cnt), MW_W'(0));
    chk("t5_allowin", MW_W'(bus.M_allowin), MW_W'(1));
    cyc();
    rstn = 1'b1;
    cyc(); cyc();

    chk("sb_empty", MW_W'(sb.size()), MW_W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage. It accepts the E->M payload and the load/store request that execute has already issued to the data SRAM.
- It waits a variable number of cycles for the SRAM response, then aligns and sign- or zero-extends load data.
- It passes the result to writeback through the valid/allowin handshake and drives a forwarding bus back to decode.
- On flush it discards responses that are still outstanding.

Parameters:
- CSR_W, 79, width of the CSR sideband (addr 14 + we 1 + wmask 32 + wdata 32), passed through unmodified.
- EX_W, 10, width of the exception sideband (ex 1 + ecode 8 + esubcode 1), passed through unmodified.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- W_allowin  in  1  writeback can accept this cycle.
- M_allowin  out  1  this stage can accept from execute.
- EM_valid  in  1  execute payload valid.
- em_pc  in  32  instruction PC.
- em_rf_wdata  in  32  ALU/CSR result.
- em_gr_we  in  1  register-file write enable.
- em_dest  in  5  destination register.
- em_res_from_mem  in  4  load type: [3] word, [1] half, [0] byte, [2] unsigned extend.
- em_mem_req  in  1  execute issued an SRAM request (load or store).
- em_addr_lo  in  2  vaddr[1:0].
- em_ex  in  EX_W  exception sideband.
- em_csr  in  CSR_W  CSR sideband.
- flush  in  1  exception/ertn flush, one-cycle pulse.
- data_sram_data_ok  in  1  response strobe for the oldest outstanding request.
- data_sram_rdata  in  32  response data, valid with data_ok.
- MW_valid  out  1  writeback payload valid.
- MW_bus  out  70+EX_W+CSR_W  {pc, rf_wdata, gr_we, dest, ex, csr}.
- MD_for_bus  out  39  {pending 1, dest 5, wdata 32, csr_we 1}.

Behaviour:
- Reset (async, rstn low): M_valid=0, state=IDLE, drop_cnt=0, all payload registers 0. Consequently MW_valid=0 and MD_for_bus=0.
- Capture: when EM_valid && M_allowin, the payload is registered, M_valid<=1 and state<=WAIT if em_mem_req else DONE.
- States:
  - IDLE: nothing held.
  - WAIT: memory op outstanding. ready_go=0.
  - DONE: result final, ready_go=1.
- WAIT->DONE transitions on data_sram_data_ok while drop_cnt==0. data_sram_rdata is captured into rdata_r on that cycle; there is no pass-through, so the earliest MW_valid is the next cycle.
- DONE->IDLE when W_allowin, unless a new capture happens in the same cycle (capture wins).
- Handshake signals:
  - MW_valid = M_valid && ready_go && !flush.
  - M_allowin = !M_valid || (ready_go && W_allowin).
- Load alignment:
  - byte select = rdata_r >> (8*addr_lo); half select = rdata_r >> (16*addr_lo[1]).
  - Sign-extend unless res_from_mem[2].
  - Final wdata = loaded value if any of res_from_mem[3,1,0], else em_rf_wdata.
  - Stores complete on data_ok with wdata = em_rf_wdata and gr_we = 0 as provided.
- Exception on entry: if em_ex[0]=1 the op was not issued. State goes straight to DONE, and em_mem_req is ignored.
- Flush:
  - M_valid<=0 and state<=IDLE.
  - If state==WAIT and data_ok is not in the same cycle, drop_cnt increments.
  - If an EM capture coincides with flush, it is discarded.
- Dropping stale responses:
  - While drop_cnt>0, each data_ok decrements drop_cnt and is ignored.
  - drop_cnt is 2 bits and saturates at 3. A flush request in that case is a design error, flagged by an assertion.
- Accepting new ops while responses are outstanding:
  - A new capture is allowed while drop_cnt>0.
  - Its response is the first data_ok after drop_cnt reaches 0.
- MD_for_bus:
  - dest is masked to 0 unless M_valid && gr_we.
  - pending = M_valid && state==WAIT && load.
  - csr_we = csr.we && M_valid.

Optional Feature:
- Macro: MEM_FAST_DATA_OK_EN.
- Defined: in WAIT, a data_ok with drop_cnt==0 makes ready_go=1 in the same cycle. The aligned data is taken from data_sram_rdata combinationally, so load-to-writeback takes 1 cycle fewer.
- Undefined: behaviour exactly as described above (registered response, one extra cycle).

Test Plan:
1. ld.w, addr_lo=0, data_ok 3 cycles after capture, rdata=0x8000_00F0, W_allowin=1 -> MW_valid rises the cycle after data_ok, rf_wdata=0x8000_00F0; M_allowin=0 throughout WAIT.
2. ld.b addr_lo=3 signed with rdata=0x80FF_FFFF -> 0xFFFF_FF80; ld.hu addr_lo=2 with rdata=0x8001_0000 -> 0x0000_8001.
3. Load in WAIT, flush pulse, then a new ld.w captured; stale data_ok rdata=0x1111_1111, then data_ok rdata=0x2222_2222 -> only 0x2222_2222 is written, drop_cnt returns to 0.
4. Non-memory add in DONE with W_allowin=0 for 4 cycles -> MW_bus held stable, M_allowin=0; on W_allowin=1 the next EM payload is accepted in the same cycle.
5. Load in WAIT, rstn asserted low asynchronously mid-cycle -> MW_valid=0 and MD_for_bus=0 immediately, state=IDLE, drop_cnt=0.
6. EM with em_ex[0]=1 and mem_req=1 -> DONE next cycle with no data_ok needed, ex sideband passed through unchanged.
